// File: rtl/isp_window_seq_ctrl_pkg.sv
// Shared definitions for the 5x5 window frame sequencer and its window.
// State encoding, error codes and bayer start phases.
package isp_window_seq_ctrl_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
  localparam logic [ST_W-1:0] ST_LOAD = 3'd1;
  localparam logic [ST_W-1:0] ST_RUN  = 3'd2;
  localparam logic [ST_W-1:0] ST_DONE = 3'd3;
  localparam logic [ST_W-1:0] ST_ERR  = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CFG  = 2'd1;
  localparam logic [1:0] ERR_SYNC = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [3:0] BAYER_RGGB = 4'b0001;
  localparam logic [3:0] BAYER_GRBG = 4'b0010;
  localparam logic [3:0] BAYER_GBRG = 4'b0100;
  localparam logic [3:0] BAYER_BGGR = 4'b1000;

  function automatic logic bayer_ok(input logic [3:0] b);
    logic ok;
    case (b)
      BAYER_RGGB,
      BAYER_GRBG,
      BAYER_GBRG,
      BAYER_BGGR: ok = 1'b1;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/isp_frame_cnt.sv
// Raster h/v position counter with last-pixel flag.
// Wraps to (0,0) after the last pixel so back-to-back frames need no clear.
module isp_frame_cnt #(
  parameter int HW = 11,
  parameter int VW = 11
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [HW-1:0] i_h_active,
  input  logic [VW-1:0] i_v_active,
  output logic          o_last
);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_h_end;
  logic          w_v_end;

  assign w_h_end = (r_h == i_h_active - HW'(1));
  assign w_v_end = (r_v == i_v_active - VW'(1));
  assign o_last  = w_h_end & w_v_end;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_clr) begin
      r_h <= '0;
      r_v <= '0;
    end else if (i_en) begin
      if (w_h_end) begin
        r_h <= '0;
        r_v <= w_v_end ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
    end
  end

endmodule

// File: rtl/isp_window_seq_ctrl.sv
// Frame sequencer in front of the 5x5 window line-buffer stage.
// Latches config, resets the window, gates pixels and checks frame sync.
module isp_window_seq_ctrl
  import isp_window_seq_ctrl_pkg::*;
#(
  parameter int          DW         = 8,
  parameter int          HW         = 11,
  parameter int          VW         = 11,
  parameter int          RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [HW-1:0] cfg_h_active,
  input  logic [VW-1:0] cfg_v_active,
  input  logic [3:0]    cfg_bayer,
  input  logic          cfg_continuous,
  input  logic          irq_clr,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  input  logic          dn_ready,
  input  logic          win_end_flag,
  input  logic          win_isp_int,
  output logic          win_rst_n,
  output logic          win_clken,
  output logic [DW-1:0] win_din,
  output logic [HW-1:0] win_h_active,
  output logic [VW-1:0] win_v_active,
  output logic [3:0]    win_bayer_start,
  output logic          busy,
  output logic          frame_done,
  output logic          irq_done,
  output logic          irq_err,
  output logic [1:0]    err_code,
  output logic [15:0]   frame_cnt
);

  localparam int RCW = $clog2(RST_CYCLES + 1);
  localparam logic [RCW-1:0] RST_LIM = RCW'(RST_CYCLES - 1);
  localparam logic        WD_EN  = (TIMEOUT != 0);
  localparam logic [15:0] WD_LIM = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_nxt;
  logic [HW-1:0]   r_h_act;
  logic [VW-1:0]   r_v_act;
  logic [3:0]      r_bayer;
  logic [RCW-1:0]  r_rst_cnt;
  logic [15:0]     r_wdog;
  logic [15:0]     r_frame_cnt;
  logic            r_irq_done;
  logic            r_irq_err;
  logic [1:0]      r_err_code;

  logic       w_idle;
  logic       w_load;
  logic       w_run;
  logic       w_done;
  logic       w_err;
  logic       w_clken;
  logic       w_last;
  logic       w_cfg_ok;
  logic       w_sync_err;
  logic       w_bay_err;
  logic       w_wd_hit;
  logic       w_err_set;
  logic [1:0] w_err_code;

  assign w_idle = (r_state == ST_IDLE);
  assign w_load = (r_state == ST_LOAD);
  assign w_run  = (r_state == ST_RUN);
  assign w_done = (r_state == ST_DONE);
  assign w_err  = (r_state == ST_ERR);

  assign pix_ready = w_run & dn_ready & ~abort;
  assign w_clken   = pix_valid & pix_ready;
  assign win_clken = w_clken;
  assign win_din   = w_run ? pix_data : '0;
  assign win_rst_n = w_run | w_done;

  assign win_h_active    = r_h_act;
  assign win_v_active    = r_v_act;
  assign win_bayer_start = r_bayer;

  assign busy       = ~w_idle;
  assign frame_done = w_done & ~abort;
  assign irq_done   = r_irq_done;
  assign irq_err    = r_irq_err;
  assign err_code   = r_err_code;
  assign frame_cnt  = r_frame_cnt;

  isp_frame_cnt #(
    .HW (HW),
    .VW (VW)
  ) u_frame_cnt (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_clr      (~win_rst_n),
    .i_en       (w_clken),
    .i_h_active (r_h_act),
    .i_v_active (r_v_act),
    .o_last     (w_last)
  );

  assign w_cfg_ok = (cfg_h_active >= HW'(5))
                  & (cfg_v_active >= VW'(5))
                  & bayer_ok(cfg_bayer);

  // The window's flag must agree with our own count on every pixel.
  assign w_sync_err = w_clken & (w_last ^ win_end_flag);
  assign w_bay_err  = w_clken & win_isp_int;
  assign w_wd_hit   = WD_EN & w_run & ~w_clken & (r_wdog == WD_LIM);

  always_comb begin
    w_nxt      = r_state;
    w_err_set  = 1'b0;
    w_err_code = ERR_NONE;
    unique case (1'b1)
      w_idle: begin
        if (start) begin
          if (w_cfg_ok) begin
            w_nxt = ST_LOAD;
          end else begin
            w_nxt      = ST_ERR;
            w_err_set  = 1'b1;
            w_err_code = ERR_CFG;
          end
        end
      end
      w_load: begin
        if (abort)
          w_nxt = ST_IDLE;
        else if (r_rst_cnt == RST_LIM)
          w_nxt = ST_RUN;
      end
      w_run: begin
        if (abort) begin
          w_nxt = ST_IDLE;
        end else if (w_sync_err) begin
          w_nxt      = ST_ERR;
          w_err_set  = 1'b1;
          w_err_code = ERR_SYNC;
        end else if (w_bay_err) begin
          w_nxt      = ST_ERR;
          w_err_set  = 1'b1;
          w_err_code = ERR_TMO;
        end else if (w_clken & w_last) begin
          w_nxt = ST_DONE;
        end else if (w_wd_hit) begin
          w_nxt      = ST_ERR;
          w_err_set  = 1'b1;
          w_err_code = ERR_TMO;
        end
      end
      w_done: begin
        if (abort || !cfg_continuous)
          w_nxt = ST_IDLE;
        else
          w_nxt = ST_RUN;
      end
      w_err: begin
        if (irq_clr)
          w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_h_act     <= '0;
      r_v_act     <= '0;
      r_bayer     <= '0;
      r_rst_cnt   <= '0;
      r_wdog      <= '0;
      r_frame_cnt <= '0;
      r_irq_done  <= 1'b0;
      r_irq_err   <= 1'b0;
      r_err_code  <= ERR_NONE;
    end else begin
      r_state   <= w_nxt;
      r_rst_cnt <= w_load ? r_rst_cnt + RCW'(1) : '0;
      r_wdog    <= (w_run & ~w_clken) ? r_wdog + 16'd1 : '0;
      if (w_idle && start && w_cfg_ok) begin
        r_h_act     <= cfg_h_active;
        r_v_act     <= cfg_v_active;
        r_bayer     <= cfg_bayer;
        r_frame_cnt <= '0;
      end else if (frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      // Setting an interrupt wins over a same-cycle clear.
      if (irq_clr) begin
        r_irq_done <= 1'b0;
        r_irq_err  <= 1'b0;
        r_err_code <= ERR_NONE;
      end
      if (frame_done)
        r_irq_done <= 1'b1;
      if (w_err_set) begin
        r_irq_err  <= 1'b1;
        r_err_code <= w_err_code;
      end
    end
  end

endmodule

// File: tb/tb_isp_window_seq_ctrl.sv
// Directed bench for isp_window_seq_ctrl with a behavioural window model.
// Window h/v position and end flag are modelled here from cfg and win_clken.
module tb_isp_window_seq_ctrl;

  localparam int DW = 8;
  localparam int HW = 11;
  localparam int VW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [HW-1:0] cfg_h_active = 11'd8;
  logic [VW-1:0] cfg_v_active = 11'd6;
  logic [3:0]    cfg_bayer = 4'b0001;
  logic          cfg_continuous = 1'b0;
  logic          irq_clr = 1'b0;
  logic          pix_valid = 1'b1;
  logic [DW-1:0] pix_data = 8'h00;
  logic          pix_ready;
  logic          dn_ready = 1'b1;
  logic          win_end_flag;
  logic          win_isp_int = 1'b0;
  logic          win_rst_n;
  logic          win_clken;
  logic [DW-1:0] win_din;
  logic [HW-1:0] win_h_active;
  logic [VW-1:0] win_v_active;
  logic [3:0]    win_bayer_start;
  logic          busy;
  logic          frame_done;
  logic          irq_done;
  logic          irq_err;
  logic [1:0]    err_code;
  logic [15:0]   frame_cnt;

  logic          tgl = 1'b0;
  logic          force_bad = 1'b0;
  logic [HW-1:0] m_h;
  logic [VW-1:0] m_v;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_clken = 0;
  int n_done = 0;
  int n_rstlow = 0;
  int n_run = 0;
  int n_badrdy = 0;
  int last_cyc = 0;
  int done_cyc = 0;

  always #5 clk = ~clk;

  isp_window_seq_ctrl #(
    .DW         (DW),
    .HW         (HW),
    .VW         (VW),
    .RST_CYCLES (4),
    .TIMEOUT    (10)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .cfg_h_active    (cfg_h_active),
    .cfg_v_active    (cfg_v_active),
    .cfg_bayer       (cfg_bayer),
    .cfg_continuous  (cfg_continuous),
    .irq_clr         (irq_clr),
    .pix_valid       (pix_valid),
    .pix_data        (pix_data),
    .pix_ready       (pix_ready),
    .dn_ready        (dn_ready),
    .win_end_flag    (win_end_flag),
    .win_isp_int     (win_isp_int),
    .win_rst_n       (win_rst_n),
    .win_clken       (win_clken),
    .win_din         (win_din),
    .win_h_active    (win_h_active),
    .win_v_active    (win_v_active),
    .win_bayer_start (win_bayer_start),
    .busy            (busy),
    .frame_done      (frame_done),
    .irq_done        (irq_done),
    .irq_err         (irq_err),
    .err_code        (err_code),
    .frame_cnt       (frame_cnt)
  );

  // Window model: raster position advanced by win_clken, held in reset by win_rst_n.
  always @(posedge clk) begin
    if (!win_rst_n) begin
      m_h <= '0;
      m_v <= '0;
    end else if (win_clken) begin
      if (m_h == cfg_h_active - 11'd1) begin
        m_h <= '0;
        m_v <= (m_v == cfg_v_active - 11'd1) ? '0 : m_v + 11'd1;
      end else begin
        m_h <= m_h + 11'd1;
      end
    end
  end

  assign win_end_flag = !force_bad
                      && (m_h == cfg_h_active - 11'd1)
                      && (m_v == cfg_v_active - 11'd1);

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (win_clken) begin
      n_clken = n_clken + 1;
      if (n_clken == 48) last_cyc = cyc;
    end
    if (frame_done) begin
      n_done = n_done + 1;
      done_cyc = cyc;
    end
    if (busy && !win_rst_n) n_rstlow = n_rstlow + 1;
    if (win_rst_n) n_run = n_run + 1;
    if (pix_ready && !dn_ready) n_badrdy = n_badrdy + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (tgl) dn_ready = ~dn_ready;
    pix_data = pix_data + 8'd1;
    #1;
  endtask

  task automatic clr_cnt();
    n_clken = 0;
    n_done = 0;
    n_rstlow = 0;
    n_run = 0;
    n_badrdy = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_clr();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
  endtask

  // kind 0: frames done, 1: irq_err, 2: handshakes seen
  task automatic wait_for(input int kind, input int target, input int budget);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      step();
      case (kind)
        0:       hit = (n_done >= target);
        1:       hit = irq_err;
        default: hit = (n_clken >= target);
      endcase
    end
    if (!hit) check("wait_budget", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (3) step();
    check("rst_busy", busy, 0);
    check("rst_win_rst_n", win_rst_n, 0);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_clken", win_clken, 0);
    check("rst_irq", {irq_done, irq_err, err_code}, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_shadow", {win_h_active, win_v_active, win_bayer_start}, 0);
    rst_n = 1'b1;
    step();

    clr_cnt();
    pulse_start();
    wait_for(2, 20, 50);
    check("shadow_h", win_h_active, 8);
    check("shadow_v", win_v_active, 6);
    check("shadow_bayer", win_bayer_start, 4'b0001);
    check("din_pass", win_din, pix_data);
    wait_for(0, 1, 200);
    check("f1_clken", n_clken, 48);
    check("f1_rstlow", n_rstlow, 4);
    check("f1_done_lat", done_cyc - last_cyc, 1);
    check("f1_frame_cnt", frame_cnt, 1);
    check("f1_irq_done", irq_done, 1);
    check("f1_irq_err", irq_err, 0);
    check("f1_idle", busy, 0);

    clr_cnt();
    tgl = 1'b1;
    pulse_start();
    wait_for(0, 1, 300);
    tgl = 1'b0;
    dn_ready = 1'b1;
    check("f2_clken", n_clken, 48);
    check("f2_badrdy", n_badrdy, 0);
    check("f2_irq_err", irq_err, 0);
    check("f2_frame_cnt", frame_cnt, 1);

    cfg_bayer = 4'b0011;
    pulse_start();
    check("cfg_bayer_code", err_code, 1);
    check("cfg_bayer_irq", irq_err, 1);
    check("cfg_bayer_busy", busy, 1);
    pulse_clr();
    check("clr_idle", busy, 0);
    check("clr_irq", {irq_done, irq_err, err_code}, 0);
    cfg_bayer = 4'b0001;
    cfg_v_active = 11'd4;
    start = 1'b1;
    irq_clr = 1'b1;
    step();
    start = 1'b0;
    irq_clr = 1'b0;
    check("cfg_v_code", err_code, 1);
    check("err_beats_clr", irq_err, 1);
    pulse_clr();
    cfg_v_active = 11'd6;

    clr_cnt();
    force_bad = 1'b1;
    pulse_start();
    wait_for(1, 0, 200);
    force_bad = 1'b0;
    check("sync_code", err_code, 2);
    check("sync_clken", n_clken, 48);
    check("sync_no_done", n_done, 0);
    pulse_clr();

    clr_cnt();
    win_isp_int = 1'b1;
    pulse_start();
    wait_for(1, 0, 50);
    win_isp_int = 1'b0;
    check("bayer_int_code", err_code, 3);
    check("bayer_int_clken", n_clken, 1);
    pulse_clr();

    clr_cnt();
    pix_valid = 1'b0;
    pulse_start();
    wait_for(1, 0, 100);
    check("tmo_code", err_code, 3);
    check("tmo_run_cycles", n_run, 10);
    pulse_clr();
    pix_valid = 1'b1;

    clr_cnt();
    pulse_start();
    wait_for(2, 20, 50);
    abort = 1'b1;
    #1;
    check("abort_ready", pix_ready, 0);
    step();
    abort = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_clken", n_clken, 20);
    check("abort_no_done", n_done, 0);
    check("abort_win_rst", win_rst_n, 0);
    clr_cnt();
    pulse_start();
    wait_for(0, 1, 200);
    check("restart_rstlow", n_rstlow, 4);
    check("restart_clken", n_clken, 48);
    check("restart_frame_cnt", frame_cnt, 1);

    clr_cnt();
    cfg_continuous = 1'b1;
    pulse_start();
    wait_for(0, 3, 600);
    check("cont_done", n_done, 3);
    check("cont_frame_cnt", frame_cnt, 3);
    check("cont_clken", n_clken, 144);
    check("cont_rstlow", n_rstlow, 4);
    check("cont_running", {busy, win_rst_n}, 2'b11);
    abort = 1'b1;
    step();
    abort = 1'b0;
    cfg_continuous = 1'b0;
    check("cont_abort_idle", busy, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
